// File: rtl/factor_search_ctrl.sv
// Walks every candidate factor pair (i1 <= i2) of a latched target through an
// external combinational checker and reports the first match, or that none exists.
module factor_search_ctrl #(
    parameter int FW   = 4,
    parameter int PW   = 8,
    parameter int CNTW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [PW-1:0]   target,
    output logic [FW-1:0]   chk_i1,
    output logic [FW-1:0]   chk_i2,
    output logic [PW-1:0]   chk_a,
    input  logic            chk_hit,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [FW-1:0]   f1,
    output logic [FW-1:0]   f2,
    output logic [CNTW-1:0] n_eval
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [FW-1:0] F_MAX = '1;
    localparam logic [FW-1:0] F_MIN = FW'(2);

    state_t state, next_state;
    logic   last_pair;

    assign last_pair = (chk_i1 == F_MAX) && (chk_i2 == F_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort, a hit and the final pair all end the search; abort only differs in the datapath.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEARCH;
                end
            end
            SEARCH: begin
                busy = 1'b1;
                if (abort || chk_hit || last_pair) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_i1 <= '0;
            chk_i2 <= '0;
            chk_a  <= '0;
            found  <= 1'b0;
            f1     <= '0;
            f2     <= '0;
            n_eval <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        chk_a  <= target;
                        chk_i1 <= F_MIN;
                        chk_i2 <= F_MIN;
                        found  <= 1'b0;
                        f1     <= '0;
                        f2     <= '0;
                        n_eval <= '0;
                    end
                end
                SEARCH: begin
                    if (abort) begin
                        found <= 1'b0;
                    end else begin
                        n_eval <= n_eval + CNTW'(1);
                        if (chk_hit) begin
                            f1    <= chk_i1;
                            f2    <= chk_i2;
                            found <= 1'b1;
                        end else if (!last_pair) begin
                            // A new row restarts i2 at i1 so pairs are never visited twice.
                            if (chk_i2 == F_MAX) begin
                                chk_i1 <= chk_i1 + FW'(1);
                                chk_i2 <= chk_i1 + FW'(1);
                            end else begin
                                chk_i2 <= chk_i2 + FW'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_factor_search_ctrl.sv
// Drives factor_search_ctrl with directed and random targets and compares it against
// a loop-based model of the pair ordering and first-hit result.
module tb_factor_search_ctrl;

    localparam int FW   = 4;
    localparam int PW   = 8;
    localparam int CNTW = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [PW-1:0]   target;
    logic [FW-1:0]   chk_i1;
    logic [FW-1:0]   chk_i2;
    logic [PW-1:0]   chk_a;
    logic            chk_hit;
    logic            busy;
    logic            done;
    logic            found;
    logic [FW-1:0]   f1;
    logic [FW-1:0]   f2;
    logic [CNTW-1:0] n_eval;

    int checks   = 0;
    int failures = 0;
    int pair_i1[106];
    int pair_i2[106];

    factor_search_ctrl #(.FW(FW), .PW(PW), .CNTW(CNTW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .target (target),
        .chk_i1 (chk_i1),
        .chk_i2 (chk_i2),
        .chk_a  (chk_a),
        .chk_hit(chk_hit),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .f1     (f1),
        .f2     (f2),
        .n_eval (n_eval)
    );

    // Stand-in for the external checker.
    assign chk_hit = ((int'(chk_i1) * int'(chk_i2)) == int'(chk_a));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelSearch(input int t, output int mfound, output int mf1,
                               output int mf2, output int mn);
        int n;
        n      = 0;
        mfound = 0;
        mf1    = 0;
        mf2    = 0;
        mn     = 105;
        for (int a = 2; a <= 15; a++) begin
            for (int b = a; b <= 15; b++) begin
                n++;
                if (mfound == 0 && a * b == t) begin
                    mfound = 1;
                    mf1    = a;
                    mf2    = b;
                    mn     = n;
                end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_outs"},
                    int'({busy, done, found, f1, f2, n_eval, chk_i1, chk_i2, chk_a}), 0);
    endtask

    task automatic applyStimulus(input int t, input int abort_at, input bit glitch,
                                 input bit start_abort);
        int ef, e1, e2, en, edone, cycles;
        modelSearch(t, ef, e1, e2, en);
        edone = en + 1;
        if (abort_at > 0 && abort_at <= en) begin
            ef    = 0;
            e1    = 0;
            e2    = 0;
            en    = abort_at - 1;
            edone = abort_at + 1;
        end
        @(negedge clk);
        start  = 1'b1;
        abort  = start_abort;
        target = PW'(t);
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            if (cycles <= 105) begin
                checkOutput("pair", int'(chk_i1) * 16 + int'(chk_i2),
                            pair_i1[cycles] * 16 + pair_i2[cycles]);
            end
            if (cycles == abort_at) abort = 1'b1;
            if (glitch && cycles == 5) begin
                start  = 1'b1;
                target = PW'(t) ^ 8'h5a;
            end
            @(negedge clk);
            cycles++;
            start  = 1'b0;
            abort  = 1'b0;
            target = PW'(t);
        end
        checkOutput("done_cycle", cycles, edone);
        checkOutput("found", int'(found), ef);
        checkOutput("f1", int'(f1), e1);
        checkOutput("f2", int'(f2), e2);
        checkOutput("n_eval", int'(n_eval), en);
        checkOutput("busy_in_done", int'(busy), 1);
        checkOutput("chk_a", int'(chk_a), t);
        @(negedge clk);
        checkOutput("done_pulse", int'(done), 0);
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("found_held", int'(found), ef);
    endtask

    initial begin
        int k;
        int t;
        int ab;
        k = 0;
        for (int a = 2; a <= 15; a++) begin
            for (int b = a; b <= 15; b++) begin
                k++;
                pair_i1[k] = a;
                pair_i2[k] = b;
            end
        end

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Abort while idle must not start anything.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle_abort_busy", int'(busy), 0);
        checkOutput("idle_abort_done", int'(done), 0);

        applyStimulus(143, 0, 1'b0, 1'b0);
        applyStimulus(49, 0, 1'b0, 1'b0);
        applyStimulus(225, 0, 1'b0, 1'b0);
        applyStimulus(13, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        applyStimulus(211, 10, 1'b1, 1'b0);
        applyStimulus(226, 0, 1'b0, 1'b1);
        applyStimulus(4, 1, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            t  = int'($urandom_range(0, 255));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0;
            $display("[TB] random target=%0d abort_at=%0d", t, ab);
            applyStimulus(t, ab, 1'b0, 1'b0);
        end

        // Reset in the middle of a search.
        @(negedge clk);
        start  = 1'b1;
        target = 8'd77;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkAllZero("mid_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", int'({done, busy}), 0);
        end
        applyStimulus(77, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
